// File: rtl/data_mem_resp.sv
// data_mem_resp
// Single-outstanding word memory with a fixed read latency and a
// request/response handshake.
//
// Handshakes (both channels): a transfer happens on a rising clock edge
// where valid && ready are both 1. The producer holds its payload stable
// while valid=1 and ready=0; the consumer may change ready freely. Here
// req_ready is 1 only in IDLE, and resp_valid is 1 only in RESP, so the
// two transfers can never fall on the same edge.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset (array contents are kept)
//   req_valid_*  request channel: valid/ready, we (1=store), byte address,
//                byte-lane mask (stores), lane-aligned write data
//   resp_*       response channel: valid/ready, read word, error flag
//   dbg_state    current FSM state (0=IDLE, 1=ACCESS, 2=RESP)
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [1:0]  CNT_INIT   = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          execute;
  logic          range_err;
  logic          mask_ok;
  logic          acc_err;
  logic [AW-1:0] widx;

  assign widx = addr_q[AW+1:2];

  // Error decode works on the latched request, so input changes while
  // busy cannot affect the outcome.
  always_comb begin
    mask_ok = 1'b0;
    case (mask_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  end

  assign range_err = (addr_q >= ADDR_LIMIT);
  assign acc_err   = range_err | (we_q & ~mask_ok);

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    execute = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          execute = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

  // Response payload is captured at the execute edge and then held until
  // the next execute. The array read returns the pre-edge word.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (execute) begin
      err_d   = acc_err;
      rdata_d = (acc_err || we_q) ? 32'd0 : mem_q[widx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      mask_q  <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        mask_q  <= req_mask;
        wdata_q <= req_wdata;
      end
    end
  end

  // Array has no reset; a reset on the execute edge still blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && execute && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem_q[widx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: four instances with RD_LATENCY 1..4 (index d
// has latency d+1), DEPTH_WORDS=256. Directed scenarios followed by
// random traffic checked against a word/byte-level memory model.
module tb_data_mem_resp;

  localparam int NDUT  = 4;
  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NDUT];
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_we     [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [3:0]  req_mask   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        resp_valid [NDUT];
  logic        resp_ready [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];
  logic [1:0]  dbg_state  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_resp #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_mask  (req_mask[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [NDUT][DEPTH];

  function automatic bit model_err(input bit we, input logic [31:0] addr,
                                   input logic [3:0] mask);
    bit bad_mask;
    bad_mask = !(mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0011, 4'b1100, 4'b1111});
    return (addr >= 32'(DEPTH * 4)) || (we && bad_mask);
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one full transaction on instance d, checking exact latency,
  // payload, backpressure stability and the return to IDLE. While busy,
  // the request inputs are driven with garbage (valid high) to show they
  // are ignored.
  task automatic do_req(input int d, input bit we, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wdata,
                        input int stall, output logic [31:0] obs_rd,
                        output logic obs_err);
    int          lat;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [31:0] word;
    string       pfx;
    lat     = d + 1;
    pfx     = $sformatf("d%0d %s@%h", d, we ? "st" : "ld", addr);
    exp_err = model_err(we, addr, mask);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      word = ref_mem[d][addr[9:2]];
      if (!we) exp_rd = word;
      else begin
        for (int i = 0; i < 4; i++)
          if (mask[i]) word[8*i +: 8] = wdata[8*i +: 8];
        ref_mem[d][addr[9:2]] = word;
      end
    end

    @(negedge clk);
    chk({pfx, " ready_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_mask[d]  = mask;
    req_wdata[d] = wdata;
    @(posedge clk); #1;
    req_we[d]    = 1'($urandom_range(0, 1));
    req_addr[d]  = $urandom;
    req_mask[d]  = 4'($urandom_range(0, 15));
    req_wdata[d] = $urandom;
    chk({pfx, " busy_ready"}, 32'(req_ready[d]), 32'd0);
    chk({pfx, " busy_valid"}, 32'(resp_valid[d]), 32'd0);
    repeat (lat - 1) begin
      @(posedge clk); #1;
      chk({pfx, " early_valid"}, 32'(resp_valid[d]), 32'd0);
    end
    @(posedge clk); #1;
    chk({pfx, " lat_valid"}, 32'(resp_valid[d]), 32'd1);
    chk({pfx, " rdata"}, resp_rdata[d], exp_rd);
    chk({pfx, " err"}, 32'(resp_err[d]), 32'(exp_err));
    obs_rd  = resp_rdata[d];
    obs_err = resp_err[d];
    repeat (stall) begin
      @(posedge clk); #1;
      chk({pfx, " hold_valid"}, 32'(resp_valid[d]), 32'd1);
      chk({pfx, " hold_rdata"}, resp_rdata[d], exp_rd);
      chk({pfx, " hold_err"}, 32'(resp_err[d]), 32'(exp_err));
      chk({pfx, " hold_ready"}, 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    chk({pfx, " done_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({pfx, " done_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          d;
    bit          we;
    logic [31:0] addr;

    for (int i = 0; i < NDUT; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_mask[i] = '0; req_wdata[i] = '0;
      resp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("d%0d rst ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("d%0d rst valid", i), 32'(resp_valid[i]), 32'd0);
      chk($sformatf("d%0d rst rdata", i), resp_rdata[i], 32'd0);
      chk($sformatf("d%0d rst err", i), 32'(resp_err[i]), 32'd0);
      rst[i] = 1'b0;
    end

    // Give words 0..31 of every instance a known value.
    for (int i = 0; i < NDUT; i++)
      for (int w = 0; w < 32; w++)
        do_req(i, 1'b1, 32'(w * 4), 4'b1111, $urandom, 0, rd, er);

    // Store word then load (latency 2).
    do_req(1, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, rd, er);
    chk("sw_err", 32'(er), 32'd0);
    do_req(1, 1'b0, 32'h10, 4'b0000, 32'h0, 0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);

    // Byte merge into lane 2.
    do_req(1, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 0, rd, er);
    do_req(1, 1'b0, 32'h10, 4'b1010, 32'h12345678, 0, rd, er);
    chk("byte_merge", rd, 32'hDEAABEEF);

    // Range error, mask error, and the word survives the bad store.
    do_req(1, 1'b0, 32'h400, 4'b1111, 32'h0, 0, rd, er);
    chk("range_err", 32'(er), 32'd1);
    chk("range_rdata", rd, 32'd0);
    do_req(1, 1'b1, 32'h10, 4'b0101, 32'hFFFFFFFF, 0, rd, er);
    chk("mask_err", 32'(er), 32'd1);
    do_req(1, 1'b0, 32'h10, 4'b0000, 32'h0, 0, rd, er);
    chk("mask_err_unchanged", rd, 32'hDEAABEEF);

    // Backpressure for 5 cycles.
    do_req(1, 1'b0, 32'h10, 4'b0000, 32'h0, 5, rd, er);

    // Latency 1 and 4 extremes (exact edge checks are inside do_req).
    do_req(0, 1'b0, 32'h10, 4'b0000, 32'h0, 1, rd, er);
    do_req(3, 1'b1, 32'h7C, 4'b0011, 32'h0000CAFE, 2, rd, er);
    do_req(3, 1'b0, 32'h7C, 4'b0000, 32'h0, 0, rd, er);

    // Reset in ACCESS before the execute edge (latency 3).
    do_req(2, 1'b1, 32'h20, 4'b1111, 32'h00000000, 0, rd, er);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
    req_mask[2] = 4'b1111; req_wdata[2] = 32'h11111111;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk("rst_access valid", 32'(resp_valid[2]), 32'd0);
    chk("rst_access ready", 32'(req_ready[2]), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_access idle_valid", 32'(resp_valid[2]), 32'd0);
    end
    do_req(2, 1'b0, 32'h20, 4'b0000, 32'h0, 0, rd, er);
    chk("rst_access discarded", rd, 32'h00000000);

    // Reset while holding a response (latency 2).
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_resp pre_valid", 32'(resp_valid[1]), 32'd1);
    rst[1] = 1'b1;
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    resp_ready[1] = 1'b0;
    chk("rst_resp valid", 32'(resp_valid[1]), 32'd0);
    chk("rst_resp rdata", resp_rdata[1], 32'd0);
    chk("rst_resp err", 32'(resp_err[1]), 32'd0);
    chk("rst_resp ready", 32'(req_ready[1]), 32'd1);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      d  = $urandom_range(0, NDUT - 1);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) addr = 32'h400 + $urandom_range(0, 32'hFFFF);
      else addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      do_req(d, we, addr, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 3), rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL provide parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the array (power of two, 16..4096).
REQ-002 The block SHALL provide parameter RD_LATENCY, default 2, meaning the number of cycles from request acceptance to response (legal range 1..4).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  meaning a request is presented.
REQ-006 The block SHALL have port req_ready  output  1  meaning the block can accept a request.
REQ-007 The block SHALL have port req_we  input  1  meaning 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  meaning the byte address; word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-009 The block SHALL have port req_mask  input  4  meaning the store byte-lane enables, where bit i selects bits [8i+7:8i].
REQ-010 The block SHALL have port req_wdata  input  32  meaning the store data, already lane-aligned.
REQ-011 The block SHALL have port resp_valid  output  1  meaning a response is presented.
REQ-012 The block SHALL have port resp_ready  input  1  meaning the requester accepts the response.
REQ-013 The block SHALL have port resp_rdata  output  32  meaning the full word read (loads); 0 for stores and errors.
REQ-014 The block SHALL have port resp_err  output  1  meaning the request was rejected (range or mask).

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE, and at most one request SHALL be outstanding.
REQ-016 A request SHALL be accepted on a clock edge where req_valid&&req_ready; at that edge we/addr/mask/wdata are latched, cnt=RD_LATENCY-1, and the state goes IDLE->ACCESS.
REQ-017 In ACCESS, if cnt!=0 then cnt SHALL decrement; if cnt==0 the access SHALL execute at that edge and the state goes ACCESS->RESP.
REQ-018 Accepted at edge N, resp_valid SHALL be 1 after edge N+RD_LATENCY.
REQ-019 resp_valid, resp_rdata and resp_err SHALL stay stable in RESP until resp_ready=1; RESP->IDLE occurs on that edge, and resp_valid SHALL be 0 after it.
REQ-020 Response acceptance and new request acceptance SHALL never coincide; the minimum request spacing is RD_LATENCY+2 cycles.
REQ-021 Range error: if the latched addr >= DEPTH_WORDS*4, then resp_err=1, resp_rdata=0, and no array write occurs.
REQ-022 Mask error for a store: if mask is not one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111, then resp_err=1 and no array write occurs.
REQ-023 A legal store SHALL update exactly the masked byte lanes of the addressed word; unmasked lanes remain unchanged.
REQ-024 Loads SHALL ignore req_mask and req_wdata, and resp_rdata SHALL equal the stored word as it was before the execute edge.
REQ-025 A load following a store to the same word SHALL return the merged stored value (no hazard exists, since one request is outstanding).
REQ-026 While not in IDLE, req_valid and all req_* input changes SHALL be ignored.
REQ-027 An error SHALL not alter the state sequence or latency.

Reset
REQ-028 While rst=1 at an edge: state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0, and req_ready=1 after the edge.
REQ-029 Reset in ACCESS before the execute edge SHALL discard the pending store (array unchanged); reset in RESP SHALL drop the response.
REQ-030 Array contents SHALL not be cleared by reset.
REQ-031 rst has priority over all handshakes in the same cycle.

Verification
REQ-032 Store word then load: RD_LATENCY=2; SW addr 0x10, mask 1111, wdata 0xDEADBEEF; then load 0x10 -> resp_rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after each acceptance.
REQ-033 Byte merge: word 0x10 = 0xDEADBEEF; store mask 0100, wdata 0x00AA0000; load -> 0xDEAABEEF.
REQ-034 Errors: load addr 0x400 with DEPTH_WORDS=256 -> err=1, rdata=0; store mask 0101 -> err=1, and a reload shows the word unchanged.
REQ-035 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and data stable and req_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-store: accept store of 0x11111111 to 0x20 (prior value 0x0), assert rst during ACCESS with RD_LATENCY=3 -> resp_valid=0 and req_ready=1 after reset, and load 0x20 returns 0x00000000.
REQ-037 Latency sweep: RD_LATENCY = 1 and 4 -> resp_valid rises exactly after edges N+1 and N+4.
